axi_tx_buffered_channel: RTL and testbench
==========================================

// Module: axi_tx_buffered_channel
// PURPOSE
//  Parametrised successor of the single-beat AXI TX channel. It sources one VALID/READY channel
//  (AW/W/AR/R/B payload) from a local producer through a DEPTH-entry FIFO.
//  The producer can enqueue back-to-back beats while the slave stalls. VALID never waits on READY.
//  Sits between master/slave datapath logic and the AXI bus, one instance per channel.
// PARAMETERS
//  WIDTH      8   payload width, bits (>=1)
//  DEPTH      4   FIFO entries; power of 2, >=2
//  AFULL_LVL  3   occupancy at/above which tx_afull asserts (1..DEPTH)
// PORTS
//  ACLK      in   1              channel clock, all logic on posedge
//  ARESET    in   1              synchronous, active-high reset
//  VALID     out  1              bus VALID, registered
//  READY     in   1              bus READY from receiver
//  xDATA     out  WIDTH          bus payload
//  tx_en     in   1              producer push request
//  tx_data   in   WIDTH          producer payload, sampled when push accepted
//  tx_hold   out  1              FIFO full; producer must not push
//  tx_afull  out  1              occupancy >= AFULL_LVL
//  tx_drop   out  1              1-cycle pulse: tx_en while tx_hold (beat discarded)
//  tx_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (ARESET=1 at posedge)
//   - count=0; pointers=0; state=IDLE; VALID=0; tx_drop=0.
//   - Mid-operation: all buffered beats are discarded and VALID=0 after that edge.
//   - This is the only case where VALID falls without a handshake.
//  Storage and pointers
//   - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - count is kept separately and is AW+1 bits wide.
//  Push and pop
//   - push = tx_en & ~tx_hold.
//   - pop  = VALID & READY.
//   - Both are evaluated at the same posedge.
//  Push behaviour
//   - Writes tx_data to mem[wr_ptr], then wr_ptr+1.
//  Pop behaviour
//   - rd_ptr+1.
//  Count update
//   - count += push - pop.
//   - Simultaneous push and pop leaves count unchanged.
//  Full FIFO (count==DEPTH)
//   - tx_hold=1, so push is blocked.
//   - A pop in the same cycle still completes.
//   - tx_hold deasserts the cycle after that pop. It is combinational from count only, never from READY.
//  Empty FIFO
//   - VALID=0; xDATA='0.
//   - A push at edge N gives VALID=1 and xDATA=that beat from edge N onward.
//   - Latency: 1 cycle push-to-VALID.
//  AXI stability rule
//   - While VALID & ~READY, VALID stays 1 and xDATA stays constant.
//   - New pushes never disturb the head entry.
//  xDATA source
//   - xDATA = mem[rd_ptr] when VALID, else '0. No X is ever driven.
//  Throughput
//   - 1 beat/cycle sustained when READY=1 and tx_en=1.
//  Status outputs
//   - tx_drop is registered: 1 in the cycle after tx_en & tx_hold were sampled.
//   - tx_afull = (count >= AFULL_LVL).
//  FSM (state_t)
//   - IDLE: count==0, VALID=0.
//       -> SEND on push.
//   - SEND: VALID=1, head not yet stalled.
//       -> STALL if ~READY.
//       -> IDLE if pop & ~push & count==1.
//       -> otherwise SEND.
//   - STALL: VALID=1, head held since last cycle.
//       -> SEND on READY (pop), or IDLE if that pop empties the FIFO with no push.
//   - VALID = (state != IDLE). It must equal (count != 0); this is asserted in the RTL.
// STRUCTURE
//  Package axi_tx_pkg
//   - typedef enum logic [1:0] {IDLE, SEND, STALL} state_t.
//   - function clog2-based width helpers.
//   - Shared with the existing single-beat channel (RST state retired: sync reset lands in IDLE).
//  Sub-module axi_tx_fifo_mem
//   - DEPTH x WIDTH register array.
//   - 1 write port, 1 async read port, no reset on the data array.
//  Top holds: pointers, count, FSM, status outputs.
// TESTING
//  1. Reset, idle: ARESET=1 for 2 cycles, then tx_en=0
//     -> VALID=0, xDATA=0, tx_count=0, tx_hold=0.
//  2. Single beat: push 0xA5 with READY=1
//     -> next cycle VALID=1, xDATA=A5; one cycle later VALID=0, count=0.
//  3. Stall/fill: READY=0, push 0x01..0x04 (DEPTH=4)
//     -> xDATA=01 held steady; tx_afull at count=3; tx_hold at count=4.
//     -> 5th push 0x05 gives tx_drop pulse and count stays 4.
//  4. Drain: from test 3 raise READY=1
//     -> 01,02,03,04 on 4 consecutive cycles; tx_hold=0 after the first pop; then VALID=0.
//  5. Full with simultaneous push/pop: count=4, READY=1, tx_en=1 data 0x10
//     -> pop accepted, push blocked (tx_drop=1).
//     -> next cycle tx_hold=0, and a push of 0x10 lands behind 04.
//  6. Streaming and wrap: READY=1, tx_en=1, 10 consecutive beats 0..9
//     -> xDATA 0..9 one per cycle, pointers wrap, count stays 1.
//     -> Then ARESET mid-stream gives VALID=0 and count=0 after that edge.

Source files
------------

// File: rtl/axi_tx_buffered_channel_pkg.sv
// Shared types and width helpers for the AXI TX channel family.
// The single-beat channel's RST state is retired; synchronous reset lands in IDLE.
package axi_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy must represent 0..DEPTH, so one bit wider than the pointers.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_tx_buffered_channel_if.sv
// Bus-side VALID/READY/payload and producer-side push/status signals of one TX channel.
interface axi_tx_buffered_channel_if
    import axi_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                      VALID;
    logic                      READY;
    logic [WIDTH-1:0]          xDATA;
    logic                      tx_en;
    logic [WIDTH-1:0]          tx_data;
    logic                      tx_hold;
    logic                      tx_afull;
    logic                      tx_drop;
    logic [cnt_w(DEPTH)-1:0]   tx_count;

    modport master (
        output VALID, xDATA, tx_hold, tx_afull, tx_drop, tx_count,
        input  READY, tx_en, tx_data
    );

    modport slave (
        input  VALID, xDATA, tx_hold, tx_afull, tx_drop, tx_count,
        output READY, tx_en, tx_data
    );
endinterface

// File: rtl/axi_tx_buffered_channel_fifo_mem.sv
// DEPTH x WIDTH payload storage: one synchronous write port, one asynchronous read port.
module axi_tx_fifo_mem
    import axi_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Data array is deliberately not reset; unread entries are masked by VALID upstream.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_tx_buffered_channel.sv
// Buffered AXI TX channel: producer pushes into a DEPTH-entry FIFO, head beat is
// presented on VALID/xDATA and held stable until READY.
module axi_tx_buffered_channel
    import axi_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi_tx_buffered_channel_if.master   bus
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    logic             r_drop;

    logic             w_full;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_state != IDLE);
    assign w_push  = bus.tx_en & ~w_full;
    assign w_pop   = w_valid & bus.READY;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    axi_tx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (ACLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.tx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= IDLE;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_drop  <= bus.tx_en & w_full;
            case (r_state)
                IDLE: begin
                    if (w_push) r_state <= SEND;
                end
                SEND: begin
                    if (!bus.READY)                r_state <= STALL;
                    else if (w_count_next == '0)   r_state <= IDLE;
                    else                           r_state <= SEND;
                end
                STALL: begin
                    if (bus.READY) r_state <= (w_count_next == '0) ? IDLE : SEND;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The FSM and the occupancy counter must always agree on whether a beat is on the bus.
    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            assert (w_valid == (r_count != '0));
        end
    end

    assign bus.VALID    = w_valid;
    assign bus.xDATA    = w_valid ? w_head : '0;
    assign bus.tx_hold  = w_full;
    assign bus.tx_afull = (r_count >= CW'(AFULL_LVL));
    assign bus.tx_drop  = r_drop;
    assign bus.tx_count = r_count;
endmodule

// File: tb/tb_axi_tx_buffered_channel.sv
// Self-checking bench for axi_tx_buffered_channel against a queue-based reference model.
module tb_axi_tx_buffered_channel;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 3;

    logic clk = 1'b0;
    logic srst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] q[$];
    logic       m_drop;

    always #5 clk = ~clk;

    axi_tx_buffered_channel_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    axi_tx_buffered_channel #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .ACLK   (clk),
        .ARESET (srst),
        .bus    (bus)
    );

    // Drive one cycle of inputs, advance the model over that edge, sample 1 time unit later.
    task automatic drive_cycle(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
        bit full;
        bit pop;
        bit push;
        srst        = rst;
        bus.tx_en   = en;
        bus.tx_data = d;
        bus.READY   = rdy;
        if (rst) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            full   = (q.size() == DEPTH);
            pop    = (q.size() != 0) && rdy;
            push   = en && !full;
            m_drop = en && full;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.VALID); end
        n_tests++; if (bus.xDATA !== 8'h00) begin n_fail++; $display("FAIL reset_xdata: got %0h want 0", bus.xDATA); end
        n_tests++; if (bus.tx_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.tx_count); end
        n_tests++; if (bus.tx_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", bus.tx_hold); end
        n_tests++; if (bus.tx_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", bus.tx_drop); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_beat();
        drive_cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        n_tests++; if (bus.VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.VALID); end
        n_tests++; if (bus.xDATA !== 8'hA5) begin n_fail++; $display("FAIL single_xdata: got %0h want a5", bus.xDATA); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b want 0", bus.VALID); end
        n_tests++; if (bus.tx_count !== 3'd0) begin n_fail++; $display("FAIL single_count_after: got %0d want 0", bus.tx_count); end
        $display("[TB] test_single_beat done");
    endtask

    task automatic test_stall_fill();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b0, 1'b1, 8'(i), 1'b0);
            n_tests++; if (bus.xDATA !== 8'h01) begin n_fail++; $display("FAIL fill_xdata[%0d]: got %0h want 01", i, bus.xDATA); end
            n_tests++; if (bus.tx_count !== 3'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.tx_count, i); end
            n_tests++; if (bus.tx_afull !== (i >= AFULL_LVL)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.tx_afull, (i >= AFULL_LVL)); end
            n_tests++; if (bus.tx_hold !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_hold[%0d]: got %b want %b", i, bus.tx_hold, (i == DEPTH)); end
        end
        drive_cycle(1'b0, 1'b1, 8'h05, 1'b0);
        n_tests++; if (bus.tx_drop !== 1'b1) begin n_fail++; $display("FAIL fill_drop: got %b want 1", bus.tx_drop); end
        n_tests++; if (bus.tx_count !== 3'd4) begin n_fail++; $display("FAIL fill_count_after_drop: got %0d want 4", bus.tx_count); end
        n_tests++; if (bus.xDATA !== 8'h01) begin n_fail++; $display("FAIL fill_xdata_after_drop: got %0h want 01", bus.xDATA); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++; if (bus.tx_drop !== 1'b0) begin n_fail++; $display("FAIL fill_drop_pulse: got %b want 0", bus.tx_drop); end
        $display("[TB] test_stall_fill done");
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (bus.xDATA !== 8'(i) || bus.VALID !== 1'b1) begin n_fail++; $display("FAIL drain_head[%0d]: got valid=%b data=%0h want valid=1 data=%0h", i, bus.VALID, bus.xDATA, i); end
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
            n_tests++; if (bus.tx_count !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.tx_count, 4 - i); end
            if (i == 1) begin
                n_tests++; if (bus.tx_hold !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got %b want 0", bus.tx_hold); end
            end
        end
        n_tests++; if (bus.VALID !== 1'b0 || bus.xDATA !== 8'h00) begin n_fail++; $display("FAIL drain_empty: got valid=%b data=%0h want valid=0 data=0", bus.VALID, bus.xDATA); end
        $display("[TB] test_drain done");
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h10};
        for (int i = 1; i <= 4; i++) drive_cycle(1'b0, 1'b1, 8'(i), 1'b0);
        drive_cycle(1'b0, 1'b1, 8'h10, 1'b1);
        n_tests++; if (bus.tx_drop !== 1'b1) begin n_fail++; $display("FAIL simul_drop: got %b want 1", bus.tx_drop); end
        n_tests++; if (bus.tx_count !== 3'd3) begin n_fail++; $display("FAIL simul_count: got %0d want 3", bus.tx_count); end
        n_tests++; if (bus.tx_hold !== 1'b0) begin n_fail++; $display("FAIL simul_hold: got %b want 0", bus.tx_hold); end
        n_tests++; if (bus.xDATA !== 8'h02) begin n_fail++; $display("FAIL simul_xdata: got %0h want 02", bus.xDATA); end
        drive_cycle(1'b0, 1'b1, 8'h10, 1'b0);
        n_tests++; if (bus.tx_count !== 3'd4) begin n_fail++; $display("FAIL simul_refill_count: got %0d want 4", bus.tx_count); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.xDATA !== exp_seq[i]) begin n_fail++; $display("FAIL simul_drain[%0d]: got %0h want %0h", i, bus.xDATA, exp_seq[i]); end
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        n_tests++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b want 0", bus.VALID); end
        $display("[TB] test_full_simul done");
    endtask

    task automatic test_stream_wrap();
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
        n_tests++; if (bus.xDATA !== 8'h00 || bus.VALID !== 1'b1) begin n_fail++; $display("FAIL stream_first: got valid=%b data=%0h want valid=1 data=0", bus.VALID, bus.xDATA); end
        for (int i = 1; i <= 9; i++) begin
            drive_cycle(1'b0, 1'b1, 8'(i), 1'b1);
            n_tests++; if (bus.xDATA !== 8'(i) || bus.tx_count !== 3'd1) begin n_fail++; $display("FAIL stream[%0d]: got data=%0h count=%0d want data=%0h count=1", i, bus.xDATA, bus.tx_count, i); end
        end
        drive_cycle(1'b1, 1'b1, 8'h0A, 1'b1);
        n_tests++; if (bus.VALID !== 1'b0 || bus.tx_count !== 3'd0) begin n_fail++; $display("FAIL stream_reset: got valid=%b count=%0d want valid=0 count=0", bus.VALID, bus.tx_count); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        $display("[TB] test_stream_wrap done");
    endtask

    task automatic test_random();
        logic       rst;
        logic       en;
        logic       rdy;
        logic [7:0] d;
        logic       pv;
        logic [7:0] px;
        logic [7:0] exp_x;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            pv  = bus.VALID;
            px  = bus.xDATA;
            drive_cycle(rst, en, d, rdy);
            exp_x = (q.size() != 0) ? q[0] : 8'h00;
            n_tests++; if (bus.VALID !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", n, bus.VALID, (q.size() != 0)); end
            n_tests++; if (bus.xDATA !== exp_x) begin n_fail++; $display("FAIL rand_xdata[%0d]: got %0h want %0h", n, bus.xDATA, exp_x); end
            n_tests++; if (bus.tx_count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, bus.tx_count, q.size()); end
            n_tests++; if (bus.tx_hold !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want %b", n, bus.tx_hold, (q.size() == DEPTH)); end
            n_tests++; if (bus.tx_afull !== (q.size() >= AFULL_LVL)) begin n_fail++; $display("FAIL rand_afull[%0d]: got %b want %b", n, bus.tx_afull, (q.size() >= AFULL_LVL)); end
            n_tests++; if (bus.tx_drop !== m_drop) begin n_fail++; $display("FAIL rand_drop[%0d]: got %b want %b", n, bus.tx_drop, m_drop); end
            if (pv && !rdy && !rst) begin
                n_tests++; if (bus.VALID !== 1'b1 || bus.xDATA !== px) begin n_fail++; $display("FAIL rand_stable[%0d]: got valid=%b data=%0h want valid=1 data=%0h", n, bus.VALID, bus.xDATA, px); end
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        srst        = 1'b1;
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'h00;
        bus.READY   = 1'b0;
        m_drop      = 1'b0;
        test_reset();
        test_single_beat();
        test_stall_fill();
        test_drain();
        test_full_simul();
        test_stream_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
